txfifo_rd_ctrl: RTL and testbench
=================================

Name: txfifo_rd_ctrl

Overview:
Reader end of the MAC transmit FIFO. Single clock, synchronous active-low reset.
Drains 64-bit words from the txfifo read port (rdreq/q/rdempty) in the MAC TX clock domain. Parses each frame's length header word and presents the payload to the MAC TX datapath with SOP, EOP and last-word byte count. Handles TX backpressure, drops frames with an illegal length, and enforces a minimum idle gap between frames.

Parameters:
WIDTH, 64, FIFO/TX data width (fixed at 64; byte-lane logic assumes 8 lanes)
LEN_W, 14, width of the length field in the header word
MIN_LEN, 60, minimum legal frame length in bytes
MAX_LEN, 1514, maximum legal frame length in bytes
IFG_CYC, 2, idle cycles forced after each EOP (0 allowed)

Ports:
clk  in  1  MAC TX clock; same clock as the FIFO rdclk
reset_  in  1  synchronous active-low reset
tx_en  in  1  enables starting a new frame; sampled only in IDLE
fifo_rdreq  out  1  FIFO read request
fifo_q  in  64  FIFO read data, valid exactly one cycle after fifo_rdreq (no show-ahead)
fifo_rdempty  in  1  FIFO empty
tx_data  out  64  payload word; byte 0 in [7:0]
tx_valid  out  1  tx_data and its qualifiers are valid
tx_sop  out  1  first word of frame, qualified by tx_valid
tx_eop  out  1  last word of frame, qualified by tx_valid
tx_mod  out  3  valid bytes in the EOP word; 0 = 8 bytes; 0 on non-EOP words
tx_ready  in  1  MAC accepts the word when tx_valid && tx_ready
tx_err  out  1  one-cycle pulse when a frame is dropped
frm_cnt  out  16  frames sent, wraps at 0xFFFF
drop_cnt  out  16  frames dropped, wraps

Behaviour:
- Reset (reset_=0 at a clk edge):
  - All outputs go to 0, the state goes to IDLE, and the skid buffer and in-flight tracking are cleared.
  - A FIFO word in flight at reset is discarded.
  - Reset mid-frame abandons the frame with no EOP emitted; the FIFO itself is reset separately by its own aclr.
- Header word: bits [LEN_W-1:0] = frame length L in bytes; other bits ignored. The next W = ceil(L/8) FIFO words are the payload.
- States:
  - IDLE: if tx_en && !fifo_rdempty, assert fifo_rdreq for the header and go to HDR.
  - HDR: capture L from fifo_q.
    - L==0: pulse tx_err, drop_cnt+1, go to IFG.
    - L<MIN_LEN or L>MAX_LEN: pulse tx_err, drop_cnt+1, go to DROP.
    - Otherwise: load words_left=W, go to DATA.
  - DATA: read payload words into a 2-entry output skid buffer and present them on tx_*.
    - The first word presented carries tx_sop; the W-th word carries tx_eop and tx_mod=L[2:0].
    - When the EOP word is accepted: frm_cnt+1, go to IFG.
  - DROP: read and discard W words with no tx_valid, then go to IFG.
  - IFG: hold IFG_CYC cycles with tx_valid=0, then go to IDLE.
- Read issue rules:
  - fifo_rdreq=1 only if !fifo_rdempty, words_left>0, and (entries buffered + reads in flight − pop this cycle) < 2.
  - fifo_rdreq is never asserted while fifo_rdempty=1.
  - words_left decrements on each rdreq.
- Output rules:
  - tx_data, tx_sop, tx_eop and tx_mod hold stable while tx_valid && !tx_ready.
  - No bubbles: with the FIFO non-empty and tx_ready held at 1, throughput is one word per cycle.
  - SOP latency: 3 cycles from rdreq(header) to tx_valid(SOP).
- Single-word frame (W==1, only possible if MIN_LEN≤8): tx_sop and tx_eop are asserted together.
- tx_en deassert mid-frame has no effect; the current frame completes.
- FIFO empty mid-frame (underrun): rdreq stalls and tx_valid drops after the buffer drains. The frame resumes when data arrives. No error is flagged; an upstream writer must write whole frames.
- Counters wrap modulo 2^16 without saturation.

Test Plan:
- Legal frame: header L=64, 8 payload words 0x0001..0x0008, tx_ready=1 → tx_valid for 8 consecutive cycles, SOP on 0x0001, EOP on 0x0008 with tx_mod=0, frm_cnt=1, then 2 idle cycles.
- Odd length: L=61 → 8 words, EOP word tx_mod=5, tx_err=0.
- Backpressure: L=64 with tx_ready toggled 1,0,0,1,... → every word delivered once and in order, outputs stable while stalled, fifo_rdreq never pushes more than 2 outstanding entries.
- Illegal lengths, back-to-back: L=40 (5 words), then L=2000 (250 words), then a legal L=60 frame → tx_err pulses twice, drop_cnt=2, no tx_valid for the dropped frames, the L=60 frame is delivered intact.
- Underrun and tx_en gating: L=128 with the FIFO empty after word 5 for 10 cycles → tx_valid gap, frame completes correctly. tx_en=0 with the FIFO non-empty → fifo_rdreq stays 0.
- Reset mid-frame: assert reset_=0 during word 4 of 8 → all outputs 0 the next cycle. After release plus a FIFO reset, a new L=64 frame is sent with a correct SOP.

Source files
------------

// File: rtl/txfifo_rd_ctrl.sv
// Reader end of the MAC TX FIFO: parses the length header, streams the payload
// through a 2-entry skid buffer with SOP/EOP/mod, drops illegal frames, inserts IFG.
module txfifo_rd_ctrl #(
  parameter int WIDTH   = 64,
  parameter int LEN_W   = 14,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             tx_en,
  output logic             fifo_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_rdempty,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [2:0]       tx_mod,
  input  logic             tx_ready,
  output logic             tx_err,
  output logic [15:0]      frm_cnt,
  output logic [15:0]      drop_cnt,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DROP, S_IFG} state_t;

  localparam int     WL_W    = LEN_W - 2;
  localparam int     IFG_W   = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  localparam state_t S_AFTER = (IFG_CYC == 0) ? S_IDLE : S_IFG;

  state_t           r_state;
  logic [WL_W-1:0]  r_words_left;
  logic             r_first;
  logic             r_inflight, r_if_sop, r_if_eop;
  logic             r_v0, r_v1, r_sop0, r_eop0, r_sop1, r_eop1;
  logic [WIDTH-1:0] r_d0, r_d1;
  logic [2:0]       r_mod;
  logic [IFG_W-1:0] r_ifg;
  logic             r_err;
  logic [15:0]      r_frm, r_drop;

  logic [LEN_W-1:0] w_len;
  logic [WL_W-1:0]  w_words, w_left_issue;
  logic             w_len_zero, w_len_ok, w_first_issue;
  logic             w_pop, w_push, w_rdreq;
  logic [1:0]       w_occ;

  assign w_len      = fifo_q[LEN_W-1:0];
  assign w_words    = WL_W'(({1'b0, w_len} + (LEN_W+1)'(7)) >> 3);
  assign w_len_zero = (w_len == '0);
  assign w_len_ok   = (w_len >= LEN_W'(MIN_LEN)) && (w_len <= LEN_W'(MAX_LEN));
  assign w_pop      = r_v0 && tx_ready;
  assign w_push     = r_inflight && (r_state == S_DATA);
  // Buffered entries plus the read in flight, net of this cycle's pop.
  assign w_occ      = 2'(r_v0) + 2'(r_v1) + 2'(r_inflight) - 2'(w_pop);

  assign w_left_issue  = (r_state == S_HDR) ? w_words : r_words_left;
  assign w_first_issue = (r_state == S_HDR) ? 1'b1 : r_first;

  always_comb begin
    w_rdreq = 1'b0;
    case (r_state)
      S_IDLE: w_rdreq = tx_en && !fifo_rdempty;
      S_HDR:  w_rdreq = w_len_ok && !fifo_rdempty;
      S_DATA: w_rdreq = !fifo_rdempty && (r_words_left != '0) && (w_occ < 2'd2);
      S_DROP: w_rdreq = !fifo_rdempty && (r_words_left != '0);
      default: w_rdreq = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_first      <= 1'b0;
      r_inflight   <= 1'b0;
      r_if_sop     <= 1'b0;
      r_if_eop     <= 1'b0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_sop0       <= 1'b0;
      r_eop0       <= 1'b0;
      r_sop1       <= 1'b0;
      r_eop1       <= 1'b0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_mod        <= '0;
      r_ifg        <= '0;
      r_err        <= 1'b0;
      r_frm        <= '0;
      r_drop       <= '0;
    end else begin
      r_err      <= 1'b0;
      r_inflight <= w_rdreq;
      if (w_rdreq) begin
        r_if_sop <= w_first_issue;
        r_if_eop <= (w_left_issue == WL_W'(1));
      end

      case ({w_push, w_pop})
        2'b11: begin
          if (r_v1) begin
            r_d0 <= r_d1;  r_sop0 <= r_sop1;  r_eop0 <= r_eop1;
            r_d1 <= fifo_q; r_sop1 <= r_if_sop; r_eop1 <= r_if_eop;
          end else begin
            r_d0 <= fifo_q; r_sop0 <= r_if_sop; r_eop0 <= r_if_eop;
          end
        end
        2'b01: begin
          r_d0 <= r_d1;  r_sop0 <= r_sop1;  r_eop0 <= r_eop1;
          r_v0 <= r_v1;  r_v1   <= 1'b0;
        end
        2'b10: begin
          if (!r_v0) begin
            r_d0 <= fifo_q; r_sop0 <= r_if_sop; r_eop0 <= r_if_eop; r_v0 <= 1'b1;
          end else begin
            r_d1 <= fifo_q; r_sop1 <= r_if_sop; r_eop1 <= r_if_eop; r_v1 <= 1'b1;
          end
        end
        default: ;
      endcase

      case (r_state)
        S_IDLE: if (w_rdreq) r_state <= S_HDR;
        S_HDR: begin
          r_mod        <= w_len[2:0];
          r_words_left <= w_words - WL_W'(w_rdreq);
          r_first      <= !w_rdreq;
          r_ifg        <= IFG_W'(IFG_CYC - 1);
          if (w_len_zero) begin
            r_err   <= 1'b1;
            r_drop  <= r_drop + 16'd1;
            r_state <= S_AFTER;
          end else if (!w_len_ok) begin
            r_err   <= 1'b1;
            r_drop  <= r_drop + 16'd1;
            r_state <= S_DROP;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_rdreq) begin
            r_words_left <= r_words_left - WL_W'(1);
            r_first      <= 1'b0;
          end
          if (w_pop && r_eop0) begin
            r_frm   <= r_frm + 16'd1;
            r_ifg   <= IFG_W'(IFG_CYC - 1);
            r_state <= S_AFTER;
          end
        end
        S_DROP: begin
          if (w_rdreq) r_words_left <= r_words_left - WL_W'(1);
          if (r_words_left == '0) begin
            r_ifg   <= IFG_W'(IFG_CYC - 1);
            r_state <= S_AFTER;
          end
        end
        S_IFG: begin
          if (r_ifg == '0) r_state <= S_IDLE;
          else             r_ifg   <= r_ifg - IFG_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rdreq  = w_rdreq;
  assign tx_valid    = r_v0;
  assign tx_data     = r_d0;
  assign tx_sop      = r_v0 && r_sop0;
  assign tx_eop      = r_v0 && r_eop0;
  assign tx_mod      = (r_v0 && r_eop0) ? r_mod : 3'd0;
  assign tx_err      = r_err;
  assign frm_cnt     = r_frm;
  assign drop_cnt    = r_drop;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_txfifo_rd_ctrl.sv
// Bench for txfifo_rd_ctrl: FIFO model feeding the reader, frame-level
// expected-word queue, per-cycle output checker, directed and random frames.
module tb_txfifo_rd_ctrl;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int IFG_CYC = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_, tx_en, fifo_rdreq, fifo_rdempty, tx_ready;
  logic [63:0] fifo_q, tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_err;
  logic [2:0]  tx_mod, dbg_state;
  logic [15:0] frm_cnt, drop_cnt;

  txfifo_rd_ctrl #(.WIDTH(64), .LEN_W(14), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
                   .IFG_CYC(IFG_CYC)) dut (
    .clk(clk), .reset_(reset_), .tx_en(tx_en), .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mod(tx_mod),
    .tx_ready(tx_ready), .tx_err(tx_err), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt),
    .o_dbg_state(dbg_state)
  );

  // FIFO contents (kind: 0 header, 1 legal payload, 2 dropped payload)
  logic [63:0] fq_data[$];
  int          fq_kind[$];
  // expected payload stream: {data, sop, eop, mod}
  logic [68:0] exp_q[$];

  int n_tests = 0, n_fail = 0;
  int tb_cyc = 0, ready_mode = 0;
  logic en_rand = 1'b0, no_rd = 1'b0, nobub = 1'b0, rd_pend = 1'b0;
  int exp_err = 0, exp_frm_tot = 0;

  // checker state
  int n_cyc = 0, hdr_cyc = 0, sop_cyc = 0, last_eop = -100, outst = 0;
  int frm_words = 0, err_seen = 0;
  logic [15:0] exp_frm = '0;
  logic        prev_stall = 1'b0, prev_err = 1'b0, acc_eop;
  logic [69:0] prev_vec = '0;
  logic [68:0] e;
  logic [63:0] sop_data = '0, eop_data = '0;
  logic [2:0]  eop_mod = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
    if (rd_pend) begin
      if (fq_data.size() > 0) begin
        fifo_q = fq_data.pop_front();
        void'(fq_kind.pop_front());
      end
      rd_pend = 1'b0;
    end
    fifo_rdempty = (fq_data.size() == 0);
    case (ready_mode)
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      2:       tx_ready = (tb_cyc % 3 == 0);
      default: tx_ready = 1'b1;
    endcase
    if (en_rand) tx_en = ($urandom_range(0, 3) != 0);
    tb_cyc++;
  endtask

  task automatic push_frame(input int len, input logic [63:0] base, input int nwr);
    int w; logic legal; logic [13:0] l14; logic [63:0] hdr, d; logic [2:0] m;
    logic s, eo;
    w = (len + 7) / 8;
    legal = (len >= MIN_LEN) && (len <= MAX_LEN);
    l14 = len[13:0];
    hdr = {$urandom(), $urandom()};
    hdr[13:0] = l14;
    fq_data.push_back(hdr); fq_kind.push_back(0);
    for (int i = 0; i < w; i++) begin
      d = base + 64'(i);
      if (i < nwr) begin fq_data.push_back(d); fq_kind.push_back(legal ? 1 : 2); end
      if (legal) begin
        s  = (i == 0);
        eo = (i == w - 1);
        m  = eo ? 3'(len % 8) : 3'd0;
        exp_q.push_back({d, s, eo, m});
      end
    end
    if (legal) exp_frm_tot++; else exp_err++;
    fifo_rdempty = (fq_data.size() == 0);
  endtask

  task automatic push_rest(input int len, input logic [63:0] base, input int from);
    int w;
    w = (len + 7) / 8;
    for (int i = from; i < w; i++) begin
      fq_data.push_back(base + 64'(i)); fq_kind.push_back(1);
    end
    fifo_rdempty = (fq_data.size() == 0);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || fq_data.size() != 0) && k < max_cyc) begin
      tick(); k++;
    end
    if (k >= max_cyc) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
    end
    repeat (IFG_CYC + 6) tick();
    check({name, "_err_count"}, 72'(err_seen), 72'(exp_err));
    check({name, "_frm_total"}, 72'(frm_cnt), 72'(exp_frm_tot));
  endtask

  // scoreboard / per-cycle compare
  always @(negedge clk) begin
    if (!reset_) begin
      n_cyc = 0; hdr_cyc = 0; last_eop = -100; outst = 0; frm_words = 0;
      err_seen = 0; exp_frm = '0; prev_stall = 1'b0; prev_err = 1'b0; rd_pend = 1'b0;
    end else begin
      n_cyc++;
      acc_eop = 1'b0;
      check("rdreq_while_empty", 72'(fifo_rdreq & fifo_rdempty), 72'(0));
      if (no_rd) check("rdreq_tx_en_off", 72'(fifo_rdreq), 72'(0));
      if (n_cyc - last_eop <= IFG_CYC) begin
        check("rdreq_in_ifg", 72'(fifo_rdreq), 72'(0));
        check("valid_in_ifg", 72'(tx_valid), 72'(0));
      end
      if (fifo_rdreq && fq_kind.size() > 0) begin
        if (fq_kind[0] == 0) hdr_cyc = n_cyc;
        if (fq_kind[0] == 1) outst++;
        rd_pend = 1'b1;
      end
      if (prev_stall)
        check("hold_while_stalled", 72'({tx_valid, tx_sop, tx_eop, tx_mod, tx_data}), 72'(prev_vec));
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 72'(tx_valid), 72'(0));
        end else begin
          e = exp_q[0];
          check("tx_word", 72'({tx_data, tx_sop, tx_eop, tx_mod}), 72'(e));
          if (e[4] && !prev_stall) check("sop_latency", 72'(n_cyc - hdr_cyc), 72'(3));
          if (tx_ready) begin
            void'(exp_q.pop_front());
            outst--;
            if (e[4]) begin sop_cyc = n_cyc; frm_words = 0; sop_data = tx_data; end
            frm_words++;
            if (e[3]) begin
              last_eop = n_cyc; eop_data = tx_data; eop_mod = tx_mod; acc_eop = 1'b1;
              if (nobub) check("no_bubble", 72'(n_cyc - sop_cyc + 1), 72'(frm_words));
            end
          end
        end
      end
      check("outstanding_le_2", 72'(outst > 2), 72'(0));
      check("frm_cnt", 72'(frm_cnt), 72'(exp_frm));
      if (acc_eop) exp_frm = exp_frm + 16'd1;
      if (tx_err) begin
        check("err_one_cycle", 72'(prev_err), 72'(0));
        err_seen++;
      end
      check("drop_cnt", 72'(drop_cnt), 72'(err_seen[15:0]));
      prev_stall = tx_valid && !tx_ready;
      prev_vec   = {tx_valid, tx_sop, tx_eop, tx_mod, tx_data};
      prev_err   = tx_err;
    end
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int k, len;
    reset_ = 1'b0; tx_en = 1'b0; tx_ready = 1'b1; fifo_q = '0; fifo_rdempty = 1'b1;
    repeat (3) tick();
    check("reset_valid", 72'(tx_valid), 72'(0));
    check("reset_counts", 72'({frm_cnt, drop_cnt, tx_err}), 72'(0));
    reset_ = 1'b1; tx_en = 1'b1;
    repeat (2) tick();

    // legal L=64, words 1..8, ready held high
    nobub = 1'b1;
    push_frame(64, 64'h1, 1000);
    wait_drain("legal64", 200);
    check("legal64_sop_data", 72'(sop_data), 72'(64'h1));
    check("legal64_eop_data", 72'(eop_data), 72'(64'h8));
    check("legal64_eop_mod", 72'(eop_mod), 72'(0));
    check("legal64_frm_cnt", 72'(frm_cnt), 72'(1));

    // odd length L=61
    push_frame(61, 64'h100, 1000);
    wait_drain("odd61", 200);
    check("odd61_eop_mod", 72'(eop_mod), 72'(5));
    check("odd61_no_drop", 72'(drop_cnt), 72'(0));

    // backpressure 1,0,0,...
    nobub = 1'b0; ready_mode = 2;
    push_frame(64, 64'h200, 1000);
    wait_drain("backpressure", 400);
    check("bp_frm_cnt", 72'(frm_cnt), 72'(3));
    ready_mode = 0; nobub = 1'b1;

    // illegal lengths back to back, then legal L=60
    push_frame(40, 64'h300, 1000);
    push_frame(2000, 64'h400, 1000);
    push_frame(60, 64'h500, 1000);
    wait_drain("illegal", 1500);
    check("illegal_drop_cnt", 72'(drop_cnt), 72'(2));
    check("illegal_frm_cnt", 72'(frm_cnt), 72'(4));
    check("illegal_l60_mod", 72'(eop_mod), 72'(4));

    // underrun: header + 5 words, FIFO empty 10 cycles, then the rest
    nobub = 1'b0;
    push_frame(128, 64'h600, 5);
    k = 0;
    while (fq_data.size() != 0 && k < 50) begin tick(); k++; end
    check("underrun_fifo_drained", 72'(fq_data.size()), 72'(0));
    repeat (10) tick();
    check("underrun_gap", 72'(tx_valid), 72'(0));
    push_rest(128, 64'h600, 5);
    wait_drain("underrun", 300);
    check("underrun_eop_data", 72'(eop_data), 72'(64'h60f));
    nobub = 1'b1;

    // tx_en gating
    tx_en = 1'b0; no_rd = 1'b1;
    push_frame(64, 64'h700, 1000);
    repeat (10) tick();
    check("tx_en_gate_fifo", 72'(fq_data.size()), 72'(9));
    no_rd = 1'b0; tx_en = 1'b1;
    wait_drain("tx_en", 200);
    check("tx_en_frm_cnt", 72'(frm_cnt), 72'(6));

    // reset mid-frame during word 4 of 8
    push_frame(64, 64'h800, 1000);
    k = 0;
    while (exp_q.size() > 5 && k < 100) begin tick(); k++; end
    check("pre_reset_word4", 72'(tx_data), 72'(64'h803));
    reset_ = 1'b0; tx_en = 1'b0;
    fq_data.delete(); fq_kind.delete(); exp_q.delete();
    fifo_rdempty = 1'b1; exp_err = 0; exp_frm_tot = 0;
    @(posedge clk); #1;
    check("mid_reset_outputs", 72'({tx_valid, tx_sop, tx_eop, tx_mod, tx_err, fifo_rdreq}), 72'(0));
    check("mid_reset_data", 72'(tx_data), 72'(0));
    check("mid_reset_counts", 72'({frm_cnt, drop_cnt}), 72'(0));
    reset_ = 1'b1; tx_en = 1'b1;
    repeat (2) tick();
    push_frame(64, 64'h900, 1000);
    wait_drain("post_reset", 200);
    check("post_reset_sop_data", 72'(sop_data), 72'(64'h900));
    check("post_reset_frm_cnt", 72'(frm_cnt), 72'(1));

    // random frames, random ready and tx_en
    nobub = 1'b0; ready_mode = 1; en_rand = 1'b1;
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = $urandom_range(1, MIN_LEN - 1);
        2:       len = $urandom_range(MAX_LEN + 1, 3000);
        3:       len = MIN_LEN;
        4:       len = MAX_LEN;
        default: len = $urandom_range(MIN_LEN, 300);
      endcase
      push_frame(len, 64'(f) << 32, 1000);
      if (f % 2 == 1) wait_drain("random", 6000);
    end
    en_rand = 1'b0; tx_en = 1'b1; ready_mode = 0;
    wait_drain("random_final", 6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
